// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants and types for the load/store bus interface
//
// Purpose: RV32I funct3 encodings, FSM state encoding, byte-strobe patterns
// and the response-timeout counter width used by lsu_bus_if and lsu_align.
// Ports: none (package).
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      RESP = 2'd2,
      ERR  = 2'd3
   } lsu_state_e;

   localparam logic [3:0] STRB_NONE    = 4'b0000;
   localparam logic [3:0] STRB_BYTE    = 4'b0001;
   localparam logic [3:0] STRB_HALF_LO = 4'b0011;
   localparam logic [3:0] STRB_HALF_HI = 4'b1100;
   localparam logic [3:0] STRB_WORD    = 4'b1111;

   localparam int TO_CNT_W = 8;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational byte-lane alignment for RV32I loads/stores
//
// Purpose: request-side legality check plus store strobe/lane replication,
// and response-side lane select with sign/zero extension.
// Ports:
//   st_store_i, st_funct3_i, st_off_i, st_wdata_i : incoming request
//   st_wstrb_o, st_wdata_o                        : bus strobes / lane data
//   st_bad_o                                      : illegal funct3 or misaligned
//   ld_funct3_i, ld_off_i                         : latched load op and offset
//   ld_rdata_i                                    : raw bus read word
//   ld_data_o                                     : extended load result
module lsu_align
   import lsu_pkg::*;
(
   input  logic        st_store_i,
   input  logic [2:0]  st_funct3_i,
   input  logic [1:0]  st_off_i,
   input  logic [31:0] st_wdata_i,
   output logic [3:0]  st_wstrb_o,
   output logic [31:0] st_wdata_o,
   output logic        st_bad_o,
   input  logic [2:0]  ld_funct3_i,
   input  logic [1:0]  ld_off_i,
   input  logic [31:0] ld_rdata_i,
   output logic [31:0] ld_data_o
);

   logic [31:0] ld_shift;
   logic        ld_sext;

   always_comb begin
      st_bad_o   = 1'b0;
      st_wstrb_o = STRB_NONE;
      st_wdata_o = '0;
      case (st_funct3_i)
         F3_B: begin
            st_wstrb_o = STRB_BYTE << st_off_i;
            st_wdata_o = {4{st_wdata_i[7:0]}};
         end
         F3_H: begin
            st_bad_o   = st_off_i[0];
            st_wstrb_o = st_off_i[1] ? STRB_HALF_HI : STRB_HALF_LO;
            st_wdata_o = {2{st_wdata_i[15:0]}};
         end
         F3_W: begin
            st_bad_o   = |st_off_i;
            st_wstrb_o = STRB_WORD;
            st_wdata_o = st_wdata_i;
         end
         // Unsigned variants exist only for loads.
         F3_BU: st_bad_o = st_store_i;
         F3_HU: st_bad_o = st_store_i | st_off_i[0];
         default: st_bad_o = 1'b1;
      endcase
      // Loads never drive strobes or write data onto the bus.
      if (!st_store_i) begin
         st_wstrb_o = STRB_NONE;
         st_wdata_o = '0;
      end
   end

   always_comb begin
      ld_shift = ld_rdata_i >> {ld_off_i, 3'b000};
      ld_sext  = ~ld_funct3_i[2];
      case (ld_funct3_i[1:0])
         2'b00:   ld_data_o = {{24{ld_shift[7] & ld_sext}}, ld_shift[7:0]};
         2'b01:   ld_data_o = {{16{ld_shift[15] & ld_sext}}, ld_shift[15:0]};
         default: ld_data_o = ld_shift;
      endcase
   end

endmodule

// File: rtl/lsu_bus_if.sv
// rtl/lsu_bus_if.sv - handshaked load/store bus master for the RV32I memory stage
//
// Purpose: accepts one load/store at a time, issues an aligned bus request,
// waits for the response (with timeout) and returns extended write-back data.
// Ports:
//   clk_i, rst_ni                     : clock, async active-low reset
//   req_valid_i/req_ready_o           : core request handshake
//   req_store_i, req_funct3_i,
//   req_addr_i, req_wdata_i           : request fields
//   resp_valid_o, resp_rdata_o,
//   resp_err_o                        : one-cycle completion pulse and result
//   stall_o                           : core hold while an op is outstanding
//   bus_req_valid_o/bus_req_ready_i   : bus request handshake
//   bus_we_o, bus_addr_o, bus_wstrb_o,
//   bus_wdata_o                       : bus request fields
//   bus_rsp_valid_i, bus_rsp_rdata_i,
//   bus_rsp_err_i                     : bus response
module lsu_bus_if
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_store_i,
   input  logic [2:0]            req_funct3_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  resp_valid_o,
   output logic [DATA_WIDTH-1:0] resp_rdata_o,
   output logic                  resp_err_o,
   output logic                  stall_o,
   output logic                  bus_req_valid_o,
   input  logic                  bus_req_ready_i,
   output logic                  bus_we_o,
   output logic [ADDR_WIDTH-1:0] bus_addr_o,
   output logic [3:0]            bus_wstrb_o,
   output logic [DATA_WIDTH-1:0] bus_wdata_o,
   input  logic                  bus_rsp_valid_i,
   input  logic [DATA_WIDTH-1:0] bus_rsp_rdata_i,
   input  logic                  bus_rsp_err_i
);

   // Last RESP cycle index before the timeout response is produced.
   localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

   lsu_state_e            state_q;
   logic [TO_CNT_W-1:0]   cnt_q;
   logic                  store_q;
   logic [2:0]            funct3_q;
   logic [1:0]            off_q;
   logic                  bus_req_valid_q;
   logic                  bus_we_q;
   logic [ADDR_WIDTH-1:0] bus_addr_q;
   logic [3:0]            bus_wstrb_q;
   logic [DATA_WIDTH-1:0] bus_wdata_q;
   logic                  resp_valid_q;
   logic [DATA_WIDTH-1:0] resp_rdata_q;
   logic                  resp_err_q;

   logic [3:0]            al_wstrb;
   logic [DATA_WIDTH-1:0] al_wdata;
   logic                  al_bad;
   logic [DATA_WIDTH-1:0] al_ldata;

   lsu_align u_align (
      .st_store_i  (req_store_i),
      .st_funct3_i (req_funct3_i),
      .st_off_i    (req_addr_i[1:0]),
      .st_wdata_i  (req_wdata_i),
      .st_wstrb_o  (al_wstrb),
      .st_wdata_o  (al_wdata),
      .st_bad_o    (al_bad),
      .ld_funct3_i (funct3_q),
      .ld_off_i    (off_q),
      .ld_rdata_i  (bus_rsp_rdata_i),
      .ld_data_o   (al_ldata)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         store_q         <= 1'b0;
         funct3_q        <= '0;
         off_q           <= '0;
         bus_req_valid_q <= 1'b0;
         bus_we_q        <= 1'b0;
         bus_addr_q      <= '0;
         bus_wstrb_q     <= '0;
         bus_wdata_q     <= '0;
         resp_valid_q    <= 1'b0;
         resp_rdata_q    <= '0;
         resp_err_q      <= 1'b0;
      end else begin
         // Response outputs are single-cycle; cleared unless set below.
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  cnt_q <= '0;
                  if (al_bad) begin
                     state_q      <= ERR;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                  end else begin
                     state_q         <= ADDR;
                     bus_req_valid_q <= 1'b1;
                     bus_we_q        <= req_store_i;
                     bus_addr_q      <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                     bus_wstrb_q     <= al_wstrb;
                     bus_wdata_q     <= al_wdata;
                     store_q         <= req_store_i;
                     funct3_q        <= req_funct3_i;
                     off_q           <= req_addr_i[1:0];
                  end
               end
            end
            ADDR: begin
               if (bus_req_ready_i) begin
                  bus_req_valid_q <= 1'b0;
                  state_q         <= RESP;
               end
            end
            RESP: begin
               if (bus_rsp_valid_i) begin
                  state_q      <= IDLE;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= bus_rsp_err_i;
                  resp_rdata_q <= (store_q || bus_rsp_err_i) ? '0 : al_ldata;
               end else if (cnt_q == TO_LAST) begin
                  state_q      <= IDLE;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ERR: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready_o     = (state_q == IDLE);
   // Stall covers the accept cycle itself so the core holds PC immediately.
   assign stall_o         = ((state_q == IDLE) && req_valid_i) ||
                            (state_q == ADDR) || (state_q == RESP);
   assign resp_valid_o    = resp_valid_q;
   assign resp_rdata_o    = resp_rdata_q;
   assign resp_err_o      = resp_err_q;
   assign bus_req_valid_o = bus_req_valid_q;
   assign bus_we_o        = bus_we_q;
   assign bus_addr_o      = bus_addr_q;
   assign bus_wstrb_o     = bus_wstrb_q;
   assign bus_wdata_o     = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_if.sv
// tb/tb_lsu_bus_if.sv - self-checking bench for lsu_bus_if
module tb_lsu_bus_if;

   localparam int TO = 4;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_valid_i, req_store_i;
   logic [2:0]  req_funct3_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic        req_ready_o, resp_valid_o, resp_err_o, stall_o;
   logic [31:0] resp_rdata_o;
   logic        bus_req_valid_o, bus_req_ready_i, bus_we_o;
   logic [31:0] bus_addr_o, bus_wdata_o;
   logic [3:0]  bus_wstrb_o;
   logic        bus_rsp_valid_i, bus_rsp_err_i;
   logic [31:0] bus_rsp_rdata_i;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk_i = ~clk_i;

   lsu_bus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_store_i     (req_store_i),
      .req_funct3_i    (req_funct3_i),
      .req_addr_i      (req_addr_i),
      .req_wdata_i     (req_wdata_i),
      .resp_valid_o    (resp_valid_o),
      .resp_rdata_o    (resp_rdata_o),
      .resp_err_o      (resp_err_o),
      .stall_o         (stall_o),
      .bus_req_valid_o (bus_req_valid_o),
      .bus_req_ready_i (bus_req_ready_i),
      .bus_we_o        (bus_we_o),
      .bus_addr_o      (bus_addr_o),
      .bus_wstrb_o     (bus_wstrb_o),
      .bus_wdata_o     (bus_wdata_o),
      .bus_rsp_valid_i (bus_rsp_valid_i),
      .bus_rsp_rdata_i (bus_rsp_rdata_i),
      .bus_rsp_err_i   (bus_rsp_err_i)
   );

   typedef struct {
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        berr;
      int          rdly;
      int          pdly;
      bit          norsp;
      logic [31:0] e_addr;
      logic [3:0]  e_wstrb;
      logic [31:0] e_wdata;
      logic [31:0] e_rdata;
      logic        e_err;
      int          e_lat;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: expectations from the ISA rules using plain arithmetic.
   function automatic vec_t model(input logic st, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] rd, input logic berr,
                                  input int rdly, input int pdly, input bit norsp);
      vec_t v;
      int sz, off;
      bit legal;
      logic [31:0] m, x;
      v.st = st; v.f3 = f3; v.addr = a; v.wd = wd; v.rd = rd; v.berr = berr;
      v.rdly = rdly; v.pdly = pdly; v.norsp = norsp;
      off   = int'(a[1:0]);
      sz    = 1 << int'(f3[1:0]);
      legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      legal = legal && ((off % sz) == 0);
      v.e_addr  = a & ~32'h3;
      v.e_wstrb = 4'h0;
      v.e_wdata = 32'h0;
      v.e_rdata = 32'h0;
      v.e_err   = 1'b1;
      v.e_lat   = 1;
      if (legal) begin
         if (st) v.e_wstrb = 4'(((1 << sz) - 1) << off);
         v.e_wdata = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
         m = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
         x = (rd >> (8 * off)) & m;
         if (!f3[2] && sz < 4 && x[8 * sz - 1]) x = x | ~m;
         if (norsp) begin
            v.e_lat = 2 + rdly + TO;
         end else begin
            v.e_lat   = 3 + rdly + pdly;
            v.e_err   = berr;
            v.e_rdata = (st || berr) ? 32'h0 : x;
         end
      end
      return v;
   endfunction

   // Drives one request from a negedge, plays the bus, and checks the result.
   // Returns at the negedge where resp_valid is observed.
   task automatic run_op(input string nm, input vec_t v, input bit noise);
      int  w, hs_c, nvalid, lat;
      bit  fld_ok, stall_ok, done;
      logic [31:0] g_rdata;
      logic        g_err;
      w = 0;
      while (!req_ready_o && w < 10) begin
         @(negedge clk_i);
         w++;
      end
      chk({nm, " req_ready"}, 32'(req_ready_o), 32'd1);
      req_valid_i  = 1'b1;
      req_store_i  = v.st;
      req_funct3_i = v.f3;
      req_addr_i   = v.addr;
      req_wdata_i  = v.wd;
      #1;
      stall_ok = (stall_o === 1'b1);
      @(negedge clk_i);
      req_valid_i = 1'b0;
      req_addr_i  = ~v.addr;
      req_wdata_i = ~v.wd;
      hs_c = -1; nvalid = 0; fld_ok = 1; done = 0; lat = 0;
      g_rdata = 32'hx; g_err = 1'bx;
      for (int c = 1; c <= 60 && !done; c++) begin
         bus_req_ready_i = 1'b0;
         bus_rsp_valid_i = 1'b0;
         bus_rsp_err_i   = 1'b0;
         bus_rsp_rdata_i = $urandom;
         if (resp_valid_o) begin
            done = 1; lat = c; g_rdata = resp_rdata_o; g_err = resp_err_o;
            if (stall_o !== 1'b0) stall_ok = 0;
         end else begin
            if (stall_o !== 1'b1) stall_ok = 0;
            if (bus_req_valid_o) begin
               nvalid++;
               if (bus_addr_o !== v.e_addr || bus_we_o !== v.st ||
                   bus_wstrb_o !== v.e_wstrb || (v.st && bus_wdata_o !== v.e_wdata))
                  fld_ok = 0;
               if (nvalid == v.rdly + 1) begin
                  bus_req_ready_i = 1'b1;
                  hs_c = c;
               end
            end
            if (hs_c < 0 || hs_c == c) begin
               if (noise) begin
                  bus_rsp_valid_i = 1'b1;
                  bus_rsp_err_i   = 1'($urandom);
               end
            end else if (!v.norsp && (c - hs_c - 1) == v.pdly) begin
               bus_rsp_valid_i = 1'b1;
               bus_rsp_rdata_i = v.rd;
               bus_rsp_err_i   = v.berr;
            end
            @(negedge clk_i);
         end
      end
      chk({nm, " completed"}, 32'(done), 32'd1);
      chk({nm, " latency"}, 32'(lat), 32'(v.e_lat));
      chk({nm, " resp_rdata"}, g_rdata, v.e_rdata);
      chk({nm, " resp_err"}, 32'(g_err), 32'(v.e_err));
      chk({nm, " bus_req_valid cycles"}, 32'(nvalid), (v.e_lat == 1) ? 32'd0 : 32'(v.rdly + 1));
      chk({nm, " bus fields"}, 32'(fld_ok), 32'd1);
      chk({nm, " stall"}, 32'(stall_ok), 32'd1);
   endtask

   vec_t tbl[13];
   vec_t rv;
   bit   ok;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      rst_ni = 1'b0;
      req_valid_i = 0; req_store_i = 0; req_funct3_i = 0; req_addr_i = 0; req_wdata_i = 0;
      bus_req_ready_i = 0; bus_rsp_valid_i = 1; bus_rsp_rdata_i = 32'hFFFF_FFFF; bus_rsp_err_i = 1;

      //           st f3      addr      wd            rd            be rd pd nr e_addr    e_wstrb  e_wdata       e_rdata       ee lat
      tbl[0]  = '{0, 3'b000, 32'h103, 32'h0,        32'h80FF1234, 0, 0, 0, 0, 32'h100, 4'b0000, 32'h0,        32'hFFFFFF80, 0, 3};
      tbl[1]  = '{0, 3'b101, 32'h102, 32'h0,        32'h80FF1234, 0, 0, 0, 0, 32'h100, 4'b0000, 32'h0,        32'h000080FF, 0, 3};
      tbl[2]  = '{1, 3'b001, 32'h106, 32'hDEADBEEF, 32'h5555AAAA, 0, 4, 0, 0, 32'h104, 4'b1100, 32'hBEEFBEEF, 32'h0,        0, 7};
      tbl[3]  = '{0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1, 1};
      tbl[4]  = '{0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1, 1};
      tbl[5]  = '{0, 3'b010, 32'h200, 32'h0,        32'h12345678, 0, 1, 0, 1, 32'h200, 4'b0000, 32'h0,        32'h0,        1, 7};
      tbl[6]  = '{1, 3'b000, 32'h007, 32'h12345678, 32'hFFFFFFFF, 0, 0, 2, 0, 32'h004, 4'b1000, 32'h78787878, 32'h0,        0, 5};
      tbl[7]  = '{0, 3'b001, 32'h000, 32'h0,        32'h00008001, 0, 0, 0, 0, 32'h000, 4'b0000, 32'h0,        32'hFFFF8001, 0, 3};
      tbl[8]  = '{0, 3'b010, 32'h010, 32'h0,        32'h12345678, 1, 2, 1, 0, 32'h010, 4'b0000, 32'h0,        32'h0,        1, 6};
      tbl[9]  = '{1, 3'b001, 32'h001, 32'h1,        32'h0,        0, 0, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1, 1};
      tbl[10] = '{1, 3'b100, 32'h020, 32'h1,        32'h0,        0, 0, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1, 1};
      tbl[11] = '{0, 3'b100, 32'h001, 32'h0,        32'h00009A00, 0, 0, 0, 0, 32'h000, 4'b0000, 32'h0,        32'h0000009A, 0, 3};
      tbl[12] = '{1, 3'b010, 32'h03C, 32'hCAFEF00D, 32'h0,        0, 0, 0, 0, 32'h03C, 4'b1111, 32'hCAFEF00D, 32'h0,        0, 3};

      // Reset state, with a stale bus response present during reset.
      repeat (3) @(negedge clk_i);
      chk("reset ctrl {bus_req_valid,bus_we,wstrb,resp_valid,resp_err}",
          32'({bus_req_valid_o, bus_we_o, bus_wstrb_o, resp_valid_o, resp_err_o}), 32'd0);
      chk("reset bus_addr", bus_addr_o, 32'd0);
      chk("reset bus_wdata", bus_wdata_o, 32'd0);
      chk("reset resp_rdata", resp_rdata_o, 32'd0);
      chk("reset {req_ready,stall}", 32'({req_ready_o, stall_o}), 32'b10);
      rst_ni = 1'b1;
      @(negedge clk_i);
      bus_rsp_valid_i = 0; bus_rsp_err_i = 0;
      chk("stale rsp after reset resp_valid", 32'(resp_valid_o), 32'd0);

      foreach (tbl[i]) run_op($sformatf("vec%0d", i), tbl[i], (i % 2) == 1);

      // Back-to-back: SW then LW accepted in the SW resp_valid cycle.
      run_op("b2b sw", model(1, 3'b010, 32'h80, 32'hA5A5_1234, 32'h0, 0, 0, 0, 0), 0);
      chk("b2b {resp_valid,req_ready}", 32'({resp_valid_o, req_ready_o}), 32'b11);
      run_op("b2b lw", model(0, 3'b010, 32'h80, 32'h0, 32'hA5A5_1234, 0, 0, 0, 0), 0);

      // Timeout then a late bus response must be ignored.
      run_op("to lw", model(0, 3'b010, 32'h44, 32'h0, 32'h0, 0, 0, 0, 1), 0);
      @(negedge clk_i);
      bus_rsp_valid_i = 1; bus_rsp_rdata_i = 32'h7777_7777; bus_rsp_err_i = 0;
      @(negedge clk_i);
      bus_rsp_valid_i = 0;
      ok = (resp_valid_o === 1'b0);
      @(negedge clk_i);
      ok = ok && (resp_valid_o === 1'b0);
      chk("late rsp after timeout ignored", 32'(ok), 32'd1);
      run_op("after to lh", model(0, 3'b001, 32'h46, 32'h0, 32'hF00D_0000, 0, 0, 0, 0), 0);

      // Reset while in RESP abandons the transaction.
      chk("rst seq ready", 32'(req_ready_o), 32'd1);
      req_valid_i = 1; req_store_i = 0; req_funct3_i = 3'b010; req_addr_i = 32'h40;
      @(negedge clk_i);
      req_valid_i = 0;
      chk("rst seq bus_req_valid", 32'(bus_req_valid_o), 32'd1);
      bus_req_ready_i = 1;
      @(negedge clk_i);
      bus_req_ready_i = 0;
      @(negedge clk_i);
      rst_ni = 0;
      #1;
      chk("mid rst ctrl {bus_req_valid,bus_we,wstrb,resp_valid,resp_err,stall}",
          32'({bus_req_valid_o, bus_we_o, bus_wstrb_o, resp_valid_o, resp_err_o, stall_o}), 32'd0);
      chk("mid rst bus_addr", bus_addr_o, 32'd0);
      chk("mid rst req_ready", 32'(req_ready_o), 32'd1);
      bus_rsp_valid_i = 1; bus_rsp_rdata_i = 32'h1111_2222;
      @(negedge clk_i);
      rst_ni = 1;
      @(negedge clk_i);
      bus_rsp_valid_i = 0;
      ok = 1;
      repeat (4) begin
         if (resp_valid_o !== 1'b0 || stall_o !== 1'b0) ok = 0;
         @(negedge clk_i);
      end
      chk("mid rst no resp_valid", 32'(ok), 32'd1);
      run_op("after rst lb", model(0, 3'b000, 32'h42, 32'h0, 32'h00C3_0000, 0, 0, 0, 0), 0);

      // Randomized ops against the reference model.
      for (int i = 0; i < 150; i++) begin
         logic [2:0] f3r;
         f3r = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
         if (f3r <= 3'd1 && $urandom_range(0, 2) == 0) f3r = f3r | 3'b100;
         rv = model(1'($urandom), f3r, $urandom, $urandom, $urandom,
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                    $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
         run_op($sformatf("rand%0d", i), rv, 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
